conv_seq_ctrl: RTL and testbench

CONV_SEQ_CTRL -- requirements
Module: conv_seq_ctrl

---
 rtl/conv_seq_ctrl_if.sv | 31 +++
 rtl/conv_seq_ctrl.sv | 169 ++++++++++++++++
 tb/tb_conv_seq_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/conv_seq_ctrl_if.sv
// Job/config request and memory/MAC sequencing outputs of the conv sequencer.
interface conv_seq_ctrl_if #(
  parameter int IA_AW = 10,
  parameter int W_AW  = 12
);
  logic             start;
  logic [2:0]       K;
  logic [5:0]       IMG_H;
  logic [5:0]       IMG_W;
  logic [7:0]       OC;
  logic [2:0]       STRIDE;
  logic             busy;
  logic             done;
  logic             cfg_err;
  logic             rd_en;
  logic [IA_AW-1:0] ia_addr;
  logic [W_AW-1:0]  w_addr;
  logic             mac_en;
  logic             mac_clr;
  logic             psum_valid;

  modport master (
    output start, K, IMG_H, IMG_W, OC, STRIDE,
    input  busy, done, cfg_err, rd_en, ia_addr, w_addr, mac_en, mac_clr, psum_valid
  );

  modport slave (
    input  start, K, IMG_H, IMG_W, OC, STRIDE,
    output busy, done, cfg_err, rd_en, ia_addr, w_addr, mac_en, mac_clr, psum_valid
  );
endinterface

// File: rtl/conv_seq_ctrl.sv
// Convolution tap sequencer: walks oc / window rows / window cols / ky / kx,
// issuing one memory read per cycle and steering the MAC clear/accumulate
// and psum-valid strobes in step with the memory read latency.
module conv_seq_ctrl #(
  parameter int IA_AW = 10,
  parameter int W_AW  = 12
) (
  input  logic clk,
  input  logic resetn,
  conv_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state_q;
  // latched job configuration
  logic [2:0]       k_q, s_q;
  logic [5:0]       h_q, w_q;
  logic [7:0]       ocn_q;
  logic [3:0]       kk_q;     // K*K, weight stride per output channel
  logic [8:0]       sw_q;     // STRIDE*IMG_W, ia step between window rows
  // loop counters for the tap currently on the bus
  logic [7:0]       oc_q, oc_d;
  logic [5:0]       r0_q, r0_d, c0_q, c0_d;
  logic [2:0]       ky_q, ky_d, kx_q, kx_d;
  // incremental addresses, so no multiplier sits on the per-tap path
  logic [IA_AW-1:0] rbase_q, rbase_d;  // r0*W
  logic [IA_AW-1:0] win_q, win_d;      // r0*W + c0
  logic [IA_AW-1:0] row_q, row_d;      // (r0+ky)*W + c0
  logic [IA_AW-1:0] ia_q, ia_d;
  logic [W_AW-1:0]  wbase_q, wbase_d;  // oc*K*K
  logic [W_AW-1:0]  wa_q, wa_d;
  logic             fin;
  // registered outputs and read-latency pipeline
  logic             busy_q, done_q, cfg_err_q, rd_en_q;
  logic             mac_en_q, mac_clr_q, lst_q, psv_q, drn_q;
  logic [7:0]       col_nx, row_nx;
  logic             cfg_ok, first_tap, last_tap;

  assign cfg_ok = (bus.K != 3'd0) && (bus.K <= 3'd3) && (bus.STRIDE != 3'd0) &&
                  (bus.OC != 8'd0) && (bus.IMG_H != 6'd0) && (bus.IMG_W != 6'd0) &&
                  ({3'b0, bus.K} <= bus.IMG_H) && ({3'b0, bus.K} <= bus.IMG_W);

  assign first_tap = (kx_q == 3'd0) && (ky_q == 3'd0);
  assign last_tap  = (kx_q == k_q - 3'd1) && (ky_q == k_q - 3'd1);

  // Next tap position and addresses; fin flags the final tap of the job.
  always_comb begin
    col_nx  = 8'(c0_q) + 8'(s_q);
    row_nx  = 8'(r0_q) + 8'(s_q);
    kx_d    = kx_q;    ky_d  = ky_q;  c0_d  = c0_q;  r0_d = r0_q;  oc_d = oc_q;
    rbase_d = rbase_q; win_d = win_q; row_d = row_q; ia_d = ia_q;
    wbase_d = wbase_q; wa_d  = wa_q;
    fin     = 1'b0;
    if (kx_q + 3'd1 < k_q) begin
      kx_d = kx_q + 3'd1;
      ia_d = ia_q + 1'b1;
      wa_d = wa_q + 1'b1;
    end else if (ky_q + 3'd1 < k_q) begin
      kx_d  = 3'd0;
      ky_d  = ky_q + 3'd1;
      row_d = row_q + IA_AW'(w_q);
      ia_d  = row_q + IA_AW'(w_q);
      wa_d  = wa_q + 1'b1;
    end else begin
      kx_d = 3'd0;
      ky_d = 3'd0;
      wa_d = wbase_q;
      if (col_nx + 8'(k_q) <= 8'(w_q)) begin
        c0_d  = col_nx[5:0];
        win_d = win_q + IA_AW'(s_q);
        row_d = win_q + IA_AW'(s_q);
        ia_d  = win_q + IA_AW'(s_q);
      end else if (row_nx + 8'(k_q) <= 8'(h_q)) begin
        c0_d    = 6'd0;
        r0_d    = row_nx[5:0];
        rbase_d = rbase_q + IA_AW'(sw_q);
        win_d   = rbase_q + IA_AW'(sw_q);
        row_d   = rbase_q + IA_AW'(sw_q);
        ia_d    = rbase_q + IA_AW'(sw_q);
      end else if ({1'b0, oc_q} + 9'd1 < {1'b0, ocn_q}) begin
        oc_d    = oc_q + 8'd1;
        r0_d    = 6'd0;
        c0_d    = 6'd0;
        rbase_d = '0;
        win_d   = '0;
        row_d   = '0;
        ia_d    = '0;
        wbase_d = wbase_q + W_AW'(kk_q);
        wa_d    = wbase_q + W_AW'(kk_q);
      end else begin
        fin = 1'b1;
      end
    end
  end

  // Control FSM with registered outputs plus the 2-stage MAC/psum pipeline.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      k_q <= '0; s_q <= '0; h_q <= '0; w_q <= '0; ocn_q <= '0; kk_q <= '0; sw_q <= '0;
      oc_q <= '0; r0_q <= '0; c0_q <= '0; ky_q <= '0; kx_q <= '0;
      rbase_q <= '0; win_q <= '0; row_q <= '0; ia_q <= '0; wbase_q <= '0; wa_q <= '0;
      busy_q <= 1'b0; done_q <= 1'b0; cfg_err_q <= 1'b0; rd_en_q <= 1'b0;
      mac_en_q <= 1'b0; mac_clr_q <= 1'b0; lst_q <= 1'b0; psv_q <= 1'b0; drn_q <= 1'b0;
    end else begin
      mac_en_q  <= rd_en_q;
      mac_clr_q <= rd_en_q && first_tap;
      lst_q     <= rd_en_q && last_tap;
      psv_q     <= lst_q;
      done_q    <= 1'b0;
      case (state_q)
        IDLE: if (bus.start) begin
          k_q       <= bus.K;
          s_q       <= bus.STRIDE;
          h_q       <= bus.IMG_H;
          w_q       <= bus.IMG_W;
          ocn_q     <= bus.OC;
          kk_q      <= 4'(bus.K) * 4'(bus.K);
          sw_q      <= 9'(bus.STRIDE) * 9'(bus.IMG_W);
          cfg_err_q <= !cfg_ok;
          oc_q <= '0; r0_q <= '0; c0_q <= '0; ky_q <= '0; kx_q <= '0;
          rbase_q <= '0; win_q <= '0; row_q <= '0; ia_q <= '0; wbase_q <= '0; wa_q <= '0;
          if (cfg_ok) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            rd_en_q <= 1'b1;
          end else begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        RUN: begin
          oc_q <= oc_d; r0_q <= r0_d; c0_q <= c0_d; ky_q <= ky_d; kx_q <= kx_d;
          rbase_q <= rbase_d; win_q <= win_d; row_q <= row_d; wbase_q <= wbase_d;
          ia_q <= ia_d;
          wa_q <= wa_d;
          if (fin) begin
            state_q <= DRAIN;
            rd_en_q <= 1'b0;
            ia_q    <= '0;
            wa_q    <= '0;
            drn_q   <= 1'b0;
          end
        end
        DRAIN: begin
          drn_q <= 1'b1;
          if (drn_q) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.cfg_err    = cfg_err_q;
  assign bus.rd_en      = rd_en_q;
  assign bus.ia_addr    = ia_q;
  assign bus.w_addr     = wa_q;
  assign bus.mac_en     = mac_en_q;
  assign bus.mac_clr    = mac_clr_q;
  assign bus.psum_valid = psv_q;

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Bench for conv_seq_ctrl: table of known jobs, hand sequences for reset and
// start-during-run, and random jobs against a nested-loop reference model.
module tb_conv_seq_ctrl;
  localparam int IA_AW = 10;
  localparam int W_AW  = 12;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  conv_seq_ctrl_if #(.IA_AW(IA_AW), .W_AW(W_AW)) bus();
  conv_seq_ctrl #(.IA_AW(IA_AW), .W_AW(W_AW)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  typedef struct {
    int k, h, w, oc, s;
    int exp_taps, exp_psum, exp_err;
  } vec_t;

  int n_chk = 0;
  int n_err = 0;
  int obs_ia[$];
  int obs_wa[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic drive_cfg(input int k, input int h, input int w, input int oc, input int s);
    bus.K = 3'(k); bus.IMG_H = 6'(h); bus.IMG_W = 6'(w); bus.OC = 8'(oc); bus.STRIDE = 3'(s);
  endtask

  task automatic drive_junk();
    drive_cfg($urandom_range(0, 7), $urandom_range(0, 63), $urandom_range(0, 63),
              $urandom_range(0, 255), $urandom_range(0, 7));
  endtask

  // Launch one job and compare every cycle against the model timeline:
  // taps on cycles 0..n-1 after the start edge, drain 2 cycles, done at n+2.
  task automatic run_job(input int k, input int h, input int w, input int oc, input int s,
                         input bit poke, output int taps, output int psums, output int err_o);
    int eia[$], ewa[$];
    bit eclr[$], elast[$];
    bit ok;
    int n, T;
    int e_rd, e_me, e_mc, e_pv, e_busy, e_done, e_err, e_addr;
    ok = k >= 1 && k <= 3 && s >= 1 && oc >= 1 && h >= 1 && w >= 1 && k <= h && k <= w;
    if (ok)
      for (int o = 0; o < oc; o++)
        for (int r = 0; r + k <= h; r += s)
          for (int c = 0; c + k <= w; c += s)
            for (int y = 0; y < k; y++)
              for (int x = 0; x < k; x++) begin
                eia.push_back((r + y) * w + c + x);
                ewa.push_back(o * k * k + y * k + x);
                eclr.push_back(y == 0 && x == 0);
                elast.push_back(y == k - 1 && x == k - 1);
              end
    n = eia.size();
    T = ok ? n + 3 : 1;
    obs_ia.delete(); obs_wa.delete();
    taps = 0; psums = 0; err_o = 0;
    e_rd = 0; e_me = 0; e_mc = 0; e_pv = 0; e_busy = 0; e_done = 0; e_err = 0; e_addr = 0;
    @(negedge clk);
    bus.start = 1'b1;
    drive_cfg(k, h, w, oc, s);
    @(negedge clk);
    bus.start = 1'b0;
    drive_junk();
    for (int c = 0; c <= T; c++) begin
      bit x_rd, x_me, x_mc, x_pv, x_busy, x_done;
      x_rd   = ok && c < n;
      x_me   = ok && c >= 1 && c <= n;
      x_mc   = 1'b0;
      if (x_me) x_mc = eclr[c-1];
      x_pv   = 1'b0;
      if (ok && c >= 2 && c <= n + 1) x_pv = elast[c-2];
      x_busy = ok && c <= n + 1;
      x_done = ok ? (c == n + 2) : (c == 0);
      if (bus.rd_en !== x_rd) e_rd++;
      if (bus.mac_en !== x_me) e_me++;
      if (bus.mac_clr !== x_mc) e_mc++;
      if (bus.psum_valid !== x_pv) e_pv++;
      if (bus.busy !== x_busy) e_busy++;
      if (bus.done !== x_done) e_done++;
      if (bus.cfg_err !== !ok) e_err++;
      if (x_rd && (int'(bus.ia_addr) != eia[c] || int'(bus.w_addr) != ewa[c])) e_addr++;
      if (bus.rd_en === 1'b1) begin
        taps++;
        obs_ia.push_back(int'(bus.ia_addr));
        obs_wa.push_back(int'(bus.w_addr));
      end
      if (bus.psum_valid === 1'b1) psums++;
      if (bus.done === 1'b1) err_o = int'(bus.cfg_err);
      if (poke && c == 3) begin
        bus.start = 1'b1;
        drive_junk();
      end else if (poke && c == 4) begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    chk($sformatf("rd_en timeline k%0d %0dx%0d oc%0d s%0d", k, h, w, oc, s), e_rd, 0);
    chk("mac_en timeline", e_me, 0);
    chk("mac_clr timeline", e_mc, 0);
    chk("psum_valid timeline", e_pv, 0);
    chk("busy timeline", e_busy, 0);
    chk("done timeline", e_done, 0);
    chk("cfg_err timeline", e_err, 0);
    chk("tap addresses", e_addr, 0);
    chk("tap count", taps, n);
  endtask

  task automatic chk_outs_zero(input string nm);
    chk({nm, " flags"}, int'({bus.busy, bus.done, bus.cfg_err, bus.rd_en,
                              bus.mac_en, bus.mac_clr, bus.psum_valid}), 0);
    chk({nm, " ia_addr"}, int'(bus.ia_addr), 0);
    chk({nm, " w_addr"}, int'(bus.w_addr), 0);
  endtask

  initial begin
    vec_t tbl[9];
    int t, p, e, junk;
    int w0[9];
    int org[4];
    tbl[0] = '{k:1, h:2, w:2, oc:1, s:1, exp_taps:4,  exp_psum:4,  exp_err:0};
    tbl[1] = '{k:3, h:4, w:4, oc:2, s:1, exp_taps:72, exp_psum:8,  exp_err:0};
    tbl[2] = '{k:3, h:5, w:5, oc:1, s:2, exp_taps:36, exp_psum:4,  exp_err:0};
    tbl[3] = '{k:0, h:4, w:4, oc:1, s:1, exp_taps:0,  exp_psum:0,  exp_err:1};
    tbl[4] = '{k:2, h:6, w:5, oc:3, s:3, exp_taps:48, exp_psum:12, exp_err:0};
    tbl[5] = '{k:3, h:2, w:5, oc:1, s:1, exp_taps:0,  exp_psum:0,  exp_err:1};
    tbl[6] = '{k:1, h:5, w:5, oc:1, s:3, exp_taps:4,  exp_psum:4,  exp_err:0};
    tbl[7] = '{k:4, h:8, w:8, oc:1, s:1, exp_taps:0,  exp_psum:0,  exp_err:1};
    tbl[8] = '{k:2, h:4, w:4, oc:0, s:1, exp_taps:0,  exp_psum:0,  exp_err:1};
    w0  = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    org = '{0, 2, 10, 12};

    bus.start = 1'b0;
    drive_cfg(0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk_outs_zero("reset state");
    resetn = 1'b1;

    foreach (tbl[i]) begin
      run_job(tbl[i].k, tbl[i].h, tbl[i].w, tbl[i].oc, tbl[i].s, 1'b0, t, p, e);
      chk($sformatf("table %0d taps", i), t, tbl[i].exp_taps);
      chk($sformatf("table %0d psums", i), p, tbl[i].exp_psum);
      chk($sformatf("table %0d cfg_err", i), e, tbl[i].exp_err);
      if (i == 0)
        for (int j = 0; j < 4; j++) begin
          chk("k1 2x2 ia_addr", obs_ia.size() > j ? obs_ia[j] : -1, j);
          chk("k1 2x2 w_addr", obs_wa.size() > j ? obs_wa[j] : -1, 0);
        end
      if (i == 1)
        for (int j = 0; j < 9; j++) begin
          chk("k3 4x4 win0 ia_addr", obs_ia.size() > j ? obs_ia[j] : -1, w0[j]);
          chk("k3 4x4 oc0 w_addr", obs_wa.size() > j ? obs_wa[j] : -1, j);
          chk("k3 4x4 oc1 w_addr", obs_wa.size() > 36 + j ? obs_wa[36+j] : -1, 9 + j);
        end
      if (i == 2)
        for (int j = 0; j < 4; j++)
          chk("k3 5x5 s2 window origin", obs_ia.size() > 9 * j ? obs_ia[9*j] : -1, org[j]);
    end

    // start pulsed mid-run with a different config must be ignored
    run_job(3, 4, 4, 2, 1, 1'b1, t, p, e);
    chk("restart ignored taps", t, 72);

    // one-cycle reset in the middle of a job
    @(negedge clk);
    bus.start = 1'b1;
    drive_cfg(3, 6, 6, 2, 1);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    resetn = 1'b0;
    #1;
    chk_outs_zero("async reset mid-run");
    @(negedge clk);
    chk_outs_zero("held reset");
    resetn = 1'b1;
    junk = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      junk += int'(bus.psum_valid) + int'(bus.done) + int'(bus.rd_en) + int'(bus.busy);
    end
    chk("activity after reset", junk, 0);
    run_job(3, 6, 6, 2, 1, 1'b0, t, p, e);
    chk("post-reset job psums", p, 32);

    // a large tile to reach the top of the ia address range
    run_job(1, 32, 32, 1, 1, 1'b0, t, p, e);
    chk("32x32 last ia_addr", obs_ia.size() > 0 ? obs_ia[$] : -1, 1023);

    for (int i = 0; i < 20; i++) begin
      int k, h, w, oc, s;
      k  = $urandom_range(1, 3);
      h  = $urandom_range(1, 8);
      w  = $urandom_range(1, 8);
      oc = $urandom_range(1, 3);
      s  = $urandom_range(1, 4);
      if ($urandom_range(0, 7) == 0) k = $urandom_range(0, 7);
      if ($urandom_range(0, 9) == 0) s = 0;
      if ($urandom_range(0, 9) == 0) oc = 0;
      run_job(k, h, w, oc, s, (k * k * oc > 8) && k <= h && k <= w, t, p, e);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
